test_supervisor: RTL and testbench

- Synthesizable simulation/test supervisor for f8 system benches.
- Generalises the fixed power-on-reset, trap-watch and time-limit logic of a bench into a parametrised block:
  - stretches reset;
  - watches multiple maskable trap channels;
  - detects program-signalled completion;
  - enforces a cycle timeout;
  - reports a latched pass/fail verdict with a one-cycle finish pulse.
- Sits between the bench clock and the DUT system. Usable on FPGA for self-test status LEDs.

---
 rtl/test_supervisor.sv | 186 ++++++++++++++++++
 tb/tb_test_supervisor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/test_supervisor.sv
// test_supervisor
// ---------------------------------------------------------------------------
// Purpose: bench/FPGA self-test supervisor. It does the following:
//   - stretches power-on reset into a system reset for the DUT;
//   - watches maskable trap channels;
//   - detects program-signalled completion and enforces a cycle timeout;
//   - latches exactly one pass/fail verdict, with a one-cycle finish pulse.
// All outputs are registered. There is no combinational input-to-output path.
//
// Ports:
//   clk             in   system clock, all logic on posedge
//   power_on_reset  in   synchronous active-high reset
//   trap            in   [CHANNELS]  per-channel trap request
//   trap_mask       in   [CHANNELS]  1 = channel ignored
//   done            in   program signals successful completion
//   system_reset    out  reset to the DUT system
//   cycle_count     out  [CNT_WIDTH] cycles elapsed in RUN and GRACE (saturating)
//   trap_channel    out  index of the first unmasked trap
//   trap_sticky     out  [CHANNELS]  per-channel unmasked trap seen
//   fail_trap       out  latched trap verdict
//   fail_timeout    out  latched timeout verdict
//   pass            out  latched pass verdict
//   finished        out  high while in DONE
//   finish_pulse    out  one cycle on entry to DONE
// ---------------------------------------------------------------------------
module test_supervisor #(
    parameter int CHANNELS       = 4,
    parameter int RESET_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 2050,
    parameter int GRACE_CYCLES   = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                         clk,
    input  logic                                         power_on_reset,
    input  logic [CHANNELS-1:0]                          trap,
    input  logic [CHANNELS-1:0]                          trap_mask,
    input  logic                                         done,
    output logic                                         system_reset,
    output logic [CNT_WIDTH-1:0]                         cycle_count,
    output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] trap_channel,
    output logic [CHANNELS-1:0]                          trap_sticky,
    output logic                                         fail_trap,
    output logic                                         fail_timeout,
    output logic                                         pass,
    output logic                                         finished,
    output logic                                         finish_pulse
);

    localparam int TCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int HW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int GW  = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;

    localparam logic [HW-1:0]        HOLD_LAST  = HW'(RESET_CYCLES - 1);
    localparam logic [GW-1:0]        GRACE_LAST = GW'(GRACE_CYCLES - 1);
    // Only meaningful when TIMEOUT_CYCLES != 0; the compare is gated below.
    localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_GRACE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [HW-1:0]         r_hold_cnt;
    logic [GW-1:0]         r_grace_cnt;
    logic                  r_system_reset;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic [TCW-1:0]        r_trap_channel;
    logic [CHANNELS-1:0]   r_trap_sticky;
    logic                  r_fail_trap;
    logic                  r_fail_timeout;
    logic                  r_pass;
    logic                  r_finished;
    logic                  r_finish_pulse;

    logic [CHANNELS-1:0]   w_unmasked;
    logic [TCW-1:0]        w_first_idx;
    logic [CNT_WIDTH-1:0]  w_count_inc;
    logic                  w_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unmask
            assign w_unmasked[gi] = trap[gi] & ~trap_mask[gi];
        end
    endgenerate

    // Lowest set index wins: scan from the top so lower indices overwrite.
    always_comb begin
        w_first_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_unmasked[i]) begin
                w_first_idx = TCW'(i);
            end
        end
    end

    // Saturate rather than wrap so a very long run never looks short.
    assign w_count_inc = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cycle_count == TO_LAST);

    always_ff @(posedge clk) begin
        if (power_on_reset) begin
            r_state        <= S_HOLD;
            r_hold_cnt     <= '0;
            r_grace_cnt    <= '0;
            r_system_reset <= 1'b1;
            r_cycle_count  <= '0;
            r_trap_channel <= '0;
            r_trap_sticky  <= '0;
            r_fail_trap    <= 1'b0;
            r_fail_timeout <= 1'b0;
            r_pass         <= 1'b0;
            r_finished     <= 1'b0;
            r_finish_pulse <= 1'b0;
        end else begin
            r_finish_pulse <= 1'b0;
            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state        <= S_RUN;
                        r_system_reset <= 1'b0;
                    end else begin
                        r_hold_cnt     <= r_hold_cnt + 1'b1;
                        r_system_reset <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_cycle_count <= w_count_inc;
                    r_trap_sticky <= r_trap_sticky | w_unmasked;
                    if (|w_unmasked) begin
                        r_fail_trap    <= 1'b1;
                        r_trap_channel <= w_first_idx;
                        if (GRACE_CYCLES == 0) begin
                            r_state        <= S_DONE;
                            r_finished     <= 1'b1;
                            r_finish_pulse <= 1'b1;
                        end else begin
                            r_state     <= S_GRACE;
                            r_grace_cnt <= '0;
                        end
                    end else if (done) begin
                        r_pass         <= 1'b1;
                        r_state        <= S_DONE;
                        r_finished     <= 1'b1;
                        r_finish_pulse <= 1'b1;
                    end else if (w_timeout) begin
                        r_fail_timeout <= 1'b1;
                        r_state        <= S_DONE;
                        r_finished     <= 1'b1;
                        r_finish_pulse <= 1'b1;
                    end
                end
                S_GRACE: begin
                    // Later traps are recorded but never change the verdict.
                    r_cycle_count <= w_count_inc;
                    r_trap_sticky <= r_trap_sticky | w_unmasked;
                    if (r_grace_cnt == GRACE_LAST) begin
                        r_state        <= S_DONE;
                        r_finished     <= 1'b1;
                        r_finish_pulse <= 1'b1;
                    end else begin
                        r_grace_cnt <= r_grace_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE: everything frozen until power_on_reset.
                    r_state <= S_DONE;
                end
            endcase
        end
    end

    assign system_reset = r_system_reset;
    assign cycle_count  = r_cycle_count;
    assign trap_channel = r_trap_channel;
    assign trap_sticky  = r_trap_sticky;
    assign fail_trap    = r_fail_trap;
    assign fail_timeout = r_fail_timeout;
    assign pass         = r_pass;
    assign finished     = r_finished;
    assign finish_pulse = r_finish_pulse;

endmodule

// File: tb/tb_test_supervisor.sv
// Directed bench for test_supervisor with default parameters.
module tb_test_supervisor;

    logic        clk = 1'b0;
    logic        power_on_reset;
    logic [3:0]  trap;
    logic [3:0]  trap_mask;
    logic        done;
    logic        system_reset;
    logic [31:0] cycle_count;
    logic [1:0]  trap_channel;
    logic [3:0]  trap_sticky;
    logic        fail_trap;
    logic        fail_timeout;
    logic        pass;
    logic        finished;
    logic        finish_pulse;

    int checks = 0;
    int errors = 0;

    test_supervisor dut (
        .clk            (clk),
        .power_on_reset (power_on_reset),
        .trap           (trap),
        .trap_mask      (trap_mask),
        .done           (done),
        .system_reset   (system_reset),
        .cycle_count    (cycle_count),
        .trap_channel   (trap_channel),
        .trap_sticky    (trap_sticky),
        .fail_trap      (fail_trap),
        .fail_timeout   (fail_timeout),
        .pass           (pass),
        .finished       (finished),
        .finish_pulse   (finish_pulse)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are then sampled 1 time unit later.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reset, then the 5 stretch edges; leaves the DUT at the start of RUN.
    task automatic restart();
        power_on_reset = 1'b1;
        step(1);
        power_on_reset = 1'b0;
        step(5);
    endtask

    initial begin
        power_on_reset = 1'b1;
        trap           = 4'b0000;
        trap_mask      = 4'b0000;
        done           = 1'b0;

        // 1. Reset stretch
        step(3);
        $display("txn reset: sysrst=%0b count=%0d", system_reset, cycle_count);
        chk("por_sysrst",   32'(system_reset), 32'd1);
        chk("por_count",    cycle_count,       32'd0);
        chk("por_flags",    32'({fail_trap, fail_timeout, pass, finished, finish_pulse}), 32'd0);
        chk("por_sticky",   32'(trap_sticky),  32'd0);
        chk("por_channel",  32'(trap_channel), 32'd0);
        power_on_reset = 1'b0;
        trap = 4'b1111;             // ignored in HOLD
        step(4);
        $display("txn hold4: sysrst=%0b", system_reset);
        chk("hold4_sysrst", 32'(system_reset), 32'd1);
        chk("hold4_sticky", 32'(trap_sticky),  32'd0);
        trap = 4'b0000;
        step(1);
        $display("txn hold5: sysrst=%0b count=%0d", system_reset, cycle_count);
        chk("hold5_sysrst", 32'(system_reset), 32'd0);
        chk("hold5_count",  cycle_count,       32'd0);

        // 2. Timeout
        step(2049);
        $display("txn run2049: count=%0d finished=%0b", cycle_count, finished);
        chk("to_pre_count",  cycle_count,        32'd2049);
        chk("to_pre_flag",   32'(fail_timeout),  32'd0);
        step(1);
        $display("txn timeout: count=%0d fto=%0b fin=%0b pulse=%0b", cycle_count, fail_timeout, finished, finish_pulse);
        chk("to_flag",   32'(fail_timeout), 32'd1);
        chk("to_fin",    32'(finished),     32'd1);
        chk("to_pulse",  32'(finish_pulse), 32'd1);
        chk("to_count",  cycle_count,       32'd2050);
        chk("to_pass",   32'(pass),         32'd0);
        chk("to_trap",   32'(fail_trap),    32'd0);
        done = 1'b1;                // ignored in DONE
        step(1);
        done = 1'b0;
        $display("txn done_hold: count=%0d pulse=%0b", cycle_count, finish_pulse);
        chk("to_pulse_end", 32'(finish_pulse), 32'd0);
        chk("to_frozen",    cycle_count,       32'd2050);
        chk("to_fin_hold",  32'(finished),     32'd1);
        chk("to_no_pass",   32'(pass),         32'd0);

        // 3. Trap with grace
        power_on_reset = 1'b1;
        step(1);
        chk("rst2_sysrst", 32'(system_reset), 32'd1);
        chk("rst2_flags",  32'({fail_trap, fail_timeout, pass, finished}), 32'd0);
        chk("rst2_count",  cycle_count,       32'd0);
        power_on_reset = 1'b0;
        step(5);
        step(100);
        chk("t3_count100", cycle_count, 32'd100);
        trap = 4'b0100;
        step(1);
        $display("txn trap2: ft=%0b ch=%0d sticky=%b count=%0d", fail_trap, trap_channel, trap_sticky, cycle_count);
        chk("t3_ftrap",   32'(fail_trap),    32'd1);
        chk("t3_channel", 32'(trap_channel), 32'd2);
        chk("t3_count",   cycle_count,       32'd101);
        chk("t3_fin0",    32'(finished),     32'd0);
        trap = 4'b0001;
        done = 1'b1;                // ignored in GRACE
        step(1);
        trap = 4'b0000;
        done = 1'b0;
        $display("txn grace1: ch=%0d sticky=%b", trap_channel, trap_sticky);
        chk("t3_sticky",   32'(trap_sticky),  32'd5);
        chk("t3_channel2", 32'(trap_channel), 32'd2);
        chk("t3_nopass",   32'(pass),         32'd0);
        step(3);
        chk("t3_fin_early", 32'(finished), 32'd0);
        step(1);
        $display("txn grace_end: fin=%0b pulse=%0b count=%0d", finished, finish_pulse, cycle_count);
        chk("t3_fin",    32'(finished),     32'd1);
        chk("t3_pulse",  32'(finish_pulse), 32'd1);
        chk("t3_count2", cycle_count,       32'd106);

        // 4. Masked trap then done
        restart();
        trap_mask = 4'b0010;
        step(10);
        trap = 4'b0010;
        step(1);
        trap = 4'b0000;
        $display("txn masked: ft=%0b sticky=%b", fail_trap, trap_sticky);
        chk("t4_ftrap",  32'(fail_trap),   32'd0);
        chk("t4_sticky", 32'(trap_sticky), 32'd0);
        step(189);
        chk("t4_count200", cycle_count, 32'd200);
        done = 1'b1;
        step(1);
        done = 1'b0;
        $display("txn done: pass=%0b count=%0d fin=%0b", pass, cycle_count, finished);
        chk("t4_pass",    32'(pass),        32'd1);
        chk("t4_count",   cycle_count,      32'd201);
        chk("t4_fin",     32'(finished),    32'd1);
        chk("t4_noftrap", 32'(fail_trap),   32'd0);
        chk("t4_sticky2", 32'(trap_sticky), 32'd0);
        trap_mask = 4'b0000;

        // 5. Simultaneous trap and done
        restart();
        step(3);
        trap = 4'b1000;
        done = 1'b1;
        step(1);
        trap = 4'b0000;
        done = 1'b0;
        $display("txn trap_done: ft=%0b ch=%0d pass=%0b", fail_trap, trap_channel, pass);
        chk("t5_ftrap",   32'(fail_trap),    32'd1);
        chk("t5_channel", 32'(trap_channel), 32'd3);
        chk("t5_pass",    32'(pass),         32'd0);
        chk("t5_count",   cycle_count,       32'd4);
        step(2);

        // 6. Reset mid-GRACE, then a fresh run
        power_on_reset = 1'b1;
        step(1);
        $display("txn rst_grace: sysrst=%0b ft=%0b count=%0d", system_reset, fail_trap, cycle_count);
        chk("t6_sysrst",  32'(system_reset), 32'd1);
        chk("t6_flags",   32'({fail_trap, fail_timeout, pass, finished, finish_pulse}), 32'd0);
        chk("t6_channel", 32'(trap_channel), 32'd0);
        chk("t6_sticky",  32'(trap_sticky),  32'd0);
        chk("t6_count",   cycle_count,       32'd0);
        step(3);                    // must stay in HOLD, not finish GRACE
        chk("t6_still_hold", 32'(finished), 32'd0);
        power_on_reset = 1'b0;
        step(5);
        chk("t6_release", 32'(system_reset), 32'd0);
        done = 1'b1;
        step(1);
        done = 1'b0;
        $display("txn fresh: pass=%0b count=%0d pulse=%0b", pass, cycle_count, finish_pulse);
        chk("t6_pass",  32'(pass),         32'd1);
        chk("t6_count2", cycle_count,      32'd1);
        chk("t6_pulse", 32'(finish_pulse), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
